// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regfile
// Brief    : 7-bit I2C target exposing a byte register file over SDA/SCL,
//            with a local host port for preload/readback and write notify.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(NUM_REGS)
) (
    input  logic          system_clock,
    input  logic          reset,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          lcl_we,
    input  logic [AW-1:0] lcl_addr,
    input  logic [7:0]    lcl_wdata,
    output logic [7:0]    lcl_rdata,
    output logic          wr_valid,
    output logic [AW-1:0] wr_index,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RACK      = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic [2:0]    bitcnt;
    logic [2:0]    bitcnt_nxt;
    logic          ack_phase;
    logic          ack_phase_nxt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_nxt;
    logic          rw;
    logic          rw_nxt;
    logic          sda_oe_nxt;
    logic          i2c_we;
    logic [7:0]    byte_in;
    logic          byte_done;
    logic [7:0]    rd_byte;

    logic [7:0] regs [NUM_REGS];

    // Synchronizers and history flops idle high, matching a released bus.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign byte_in   = {shift[6:0], sda_s};
    assign byte_done = scl_rise && (bitcnt == 3'd7);
    assign rd_byte   = regs[ptr];

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ST_ADDR;
        end else if (stop_det) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (byte_done) begin
                        state_nxt = (byte_in[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                ST_PTR: begin
                    if (byte_done) begin
                        state_nxt = ST_PTR_ACK;
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        state_nxt = ST_WDATA_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall && ack_phase) begin
                        state_nxt = rw ? ST_RDATA : ST_PTR;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall && ack_phase) begin
                        state_nxt = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall && (bitcnt == 3'd7)) begin
                        state_nxt = ST_RACK;
                    end
                end
                ST_RACK: begin
                    if (scl_rise && sda_s) begin
                        state_nxt = ST_IGNORE;
                    end else if (scl_fall && ack_phase) begin
                        state_nxt = ST_RDATA;
                    end
                end
                ST_IDLE, ST_IGNORE: state_nxt = state;
                default:            state_nxt = ST_IDLE;
            endcase
        end
    end

    // ack_phase: in ACK states it marks "ACK is being driven"; in RACK it
    // marks "controller ACKed, send next byte on the coming fall".
    always_comb begin
        shift_nxt     = shift;
        bitcnt_nxt    = bitcnt;
        ack_phase_nxt = ack_phase;
        ptr_nxt       = ptr;
        rw_nxt        = rw;
        sda_oe_nxt    = sda_oe;
        i2c_we        = 1'b0;
        if (start_det || stop_det) begin
            bitcnt_nxt    = 3'd0;
            ack_phase_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_nxt  = byte_in;
                        bitcnt_nxt = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            ack_phase_nxt = 1'b0;
                            if (state == ST_ADDR) begin
                                rw_nxt = sda_s;
                            end else if (state == ST_PTR) begin
                                ptr_nxt = byte_in[AW-1:0];
                            end else begin
                                i2c_we  = 1'b1;
                                ptr_nxt = ptr + 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_nxt = 1'b1;
                            sda_oe_nxt    = 1'b1;
                        end else begin
                            ack_phase_nxt = 1'b0;
                            bitcnt_nxt    = 3'd0;
                            if ((state == ST_ADDR_ACK) && rw) begin
                                shift_nxt  = rd_byte;
                                sda_oe_nxt = ~rd_byte[7];
                            end else begin
                                sda_oe_nxt = 1'b0;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt == 3'd7) begin
                            bitcnt_nxt    = 3'd0;
                            ack_phase_nxt = 1'b0;
                            sda_oe_nxt    = 1'b0;
                        end else begin
                            bitcnt_nxt = bitcnt + 3'd1;
                            shift_nxt  = {shift[6:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        ptr_nxt = ptr + 1'b1;
                        if (!sda_s) begin
                            ack_phase_nxt = 1'b1;
                        end
                    end else if (scl_fall && ack_phase) begin
                        ack_phase_nxt = 1'b0;
                        bitcnt_nxt    = 3'd0;
                        shift_nxt     = rd_byte;
                        sda_oe_nxt    = ~rd_byte[7];
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            shift     <= 8'h00;
            bitcnt    <= 3'd0;
            ack_phase <= 1'b0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_index  <= '0;
            wr_data   <= 8'h00;
        end else begin
            shift     <= shift_nxt;
            bitcnt    <= bitcnt_nxt;
            ack_phase <= ack_phase_nxt;
            ptr       <= ptr_nxt;
            rw        <= rw_nxt;
            sda_oe    <= sda_oe_nxt;
            wr_valid  <= i2c_we;
            if (i2c_we) begin
                wr_index <= ptr;
                wr_data  <= byte_in;
            end
        end
    end

    // A colliding local write to the I2C target index is dropped.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (i2c_we) begin
                regs[ptr] <= byte_in;
            end
            if (lcl_we && !(i2c_we && (lcl_addr == ptr))) begin
                regs[lcl_addr] <= lcl_wdata;
            end
        end
    end

    assign lcl_rdata = regs[lcl_addr];
    assign busy      = (state != ST_IDLE);

endmodule
`default_nettype wire
